// File: rtl/acc_stream_master_if.sv
// ---------------------------------------------------------------------------
// acc_stream_master_if
// Bundles every non-clock/reset signal of acc_stream_master: the job
// descriptor handshake, upstream weight/feature row streams, the result
// stream and the accelerator-facing instruction/data/output ports.
//   modport master : view of acc_stream_master (drives job_ready, row readys,
//                    result stream, accelerator inputs and status flags)
//   modport slave  : view of the surrounding system (host, DMA, accelerator)
// ---------------------------------------------------------------------------
interface acc_stream_master_if #(
  parameter int sys_cols   = 4,
  parameter int W_BITWIDTH = 8,
  parameter int P_BITWIDTH = 32,
  parameter int INSTR_SIZE = 32,
  parameter int CNT_W      = 16
);
  // job descriptor
  logic                           job_valid;
  logic                           job_ready;
  logic [INSTR_SIZE-1:0]          job_instr;
  logic [CNT_W-1:0]               job_nw;
  logic [CNT_W-1:0]               job_nif;
  logic [CNT_W-1:0]               job_nout;
  // upstream rows
  logic                           wrow_valid;
  logic                           wrow_ready;
  logic [sys_cols*W_BITWIDTH-1:0] wrow_data;
  logic                           ifrow_valid;
  logic                           ifrow_ready;
  logic [sys_cols*W_BITWIDTH-1:0] ifrow_data;
  // result stream
  logic                           res_valid;
  logic                           res_ready;
  logic [sys_cols*P_BITWIDTH-1:0] res_data;
  logic [sys_cols-1:0]            res_mask;
  // accelerator side
  logic                           start;
  logic                           instr_valid;
  logic [INSTR_SIZE-1:0]          instr;
  logic [sys_cols-1:0]            w_valid;
  logic [sys_cols-1:0]            if_valid;
  logic [sys_cols*W_BITWIDTH-1:0] wdata;
  logic [sys_cols*W_BITWIDTH-1:0] if_data;
  logic                           ready;
  logic [sys_cols-1:0]            read_out;
  logic [sys_cols*P_BITWIDTH-1:0] o_data;
  // status
  logic                           busy;
  logic                           done;
  logic                           err_ovf;
  logic                           err_timeout;

  modport master (
    input  job_valid, job_instr, job_nw, job_nif, job_nout,
           wrow_valid, wrow_data, ifrow_valid, ifrow_data,
           res_ready, ready, read_out, o_data,
    output job_ready, wrow_ready, ifrow_ready, res_valid, res_data, res_mask,
           start, instr_valid, instr, w_valid, if_valid, wdata, if_data,
           busy, done, err_ovf, err_timeout
  );

  modport slave (
    output job_valid, job_instr, job_nw, job_nif, job_nout,
           wrow_valid, wrow_data, ifrow_valid, ifrow_data,
           res_ready, ready, read_out, o_data,
    input  job_ready, wrow_ready, ifrow_ready, res_valid, res_data, res_mask,
           start, instr_valid, instr, w_valid, if_valid, wdata, if_data,
           busy, done, err_ovf, err_timeout
  );
endinterface

// File: rtl/acc_stream_master.sv
// ---------------------------------------------------------------------------
// acc_stream_master
// Host-side transmitter/collector for the matrix-multiply accelerator.
// Accepts a job descriptor, issues instruction + start, streams nw weight
// rows and nif feature rows to the accelerator, then waits until nout output
// rows have been captured. Output rows flagged by read_out are pushed into a
// small result FIFO that drains on a valid/ready stream independently of the
// job state.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : acc_stream_master_if.master (job, row streams, result stream,
//          accelerator ports, busy/done/err_ovf/err_timeout)
// Build option:
//   ACC_STREAM_TIMEOUT_EN : enables the DRAIN watchdog (TIMEOUT idle cycles
//                           without read_out -> err_timeout and finish job).
//                           Undefined: DRAIN waits forever, err_timeout = 0.
// ---------------------------------------------------------------------------
module acc_stream_master #(
  parameter int sys_cols   = 4,
  parameter int W_BITWIDTH = 8,
  parameter int P_BITWIDTH = 32,
  parameter int INSTR_SIZE = 32,
  parameter int CNT_W      = 16,
  parameter int RES_DEPTH  = 4,
  parameter int TIMEOUT    = 1024
) (
  input logic                 clk,
  input logic                 rst,
  acc_stream_master_if.master bus
);
  localparam int RW = sys_cols * W_BITWIDTH;
  localparam int PW = sys_cols * P_BITWIDTH;
  localparam int EW = PW + sys_cols;
  localparam int AW = $clog2(RES_DEPTH);
  localparam logic [AW:0]          FULL_C    = (AW+1)'(RES_DEPTH);
  localparam logic [CNT_W-1:0]     CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [sys_cols-1:0]  COL_ZERO  = {sys_cols{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_STREAM_W  = 3'd2,
    S_STREAM_IF = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [INSTR_SIZE-1:0] instr_r;
  logic [CNT_W-1:0]      nw_r, nif_r, nout_r;
  logic [CNT_W-1:0]      w_cnt_r, if_cnt_r, out_cnt_r;
  logic                  w_valid_r, if_valid_r;
  logic [RW-1:0]         wdata_r, if_data_r;
  logic                  err_ovf_r;
  logic [EW-1:0]         mem_r [RES_DEPTH];
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [AW:0]           count_r;

  logic job_fire_s, issue_fire_s, w_fire_s, if_fire_s;
  logic w_last_s, if_last_s, drain_ok_s;
  logic push_s, pop_s, full_s, wr_en_s, res_valid_s;
  logic [EW-1:0] rd_entry_s;
  logic watchdog_s;

  assign job_fire_s   = (state_r == S_IDLE)      && bus.job_valid;
  assign issue_fire_s = (state_r == S_ISSUE)     && bus.ready;
  assign w_fire_s     = (state_r == S_STREAM_W)  && bus.wrow_valid;
  assign if_fire_s    = (state_r == S_STREAM_IF) && bus.ifrow_valid;
  // Row counts are compared one bit wider so the +1 cannot wrap.
  assign w_last_s   = ({1'b0, w_cnt_r}  + (CNT_W+1)'(1'b1)) >= {1'b0, nw_r};
  assign if_last_s  = ({1'b0, if_cnt_r} + (CNT_W+1)'(1'b1)) >= {1'b0, nif_r};
  assign drain_ok_s = out_cnt_r >= nout_r;

  // Capture is live in every state but IDLE; a full FIFO still accepts a
  // push when the head is popped in the same cycle.
  assign push_s      = (state_r != S_IDLE) && (bus.read_out != COL_ZERO);
  assign res_valid_s = count_r != {(AW+1){1'b0}};
  assign pop_s       = res_valid_s && bus.res_ready;
  assign full_s      = count_r == FULL_C;
  assign wr_en_s     = push_s && (!full_s || pop_s);
  assign rd_entry_s  = mem_r[rd_ptr_r];

`ifdef ACC_STREAM_TIMEOUT_EN
  logic [31:0] idle_cnt_r;
  logic        err_timeout_r;

  assign watchdog_s      = idle_cnt_r >= 32'(TIMEOUT);
  assign bus.err_timeout = err_timeout_r;

  // Drain watchdog: counts idle DRAIN cycles, restarts on any read_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_r    <= 32'd0;
      err_timeout_r <= 1'b0;
    end else if (job_fire_s) begin
      idle_cnt_r    <= 32'd0;
      err_timeout_r <= 1'b0;
    end else if (state_r == S_DRAIN) begin
      if (bus.read_out != COL_ZERO)
        idle_cnt_r <= 32'd0;
      else if (!watchdog_s)
        idle_cnt_r <= idle_cnt_r + 32'd1;
      else
        idle_cnt_r <= idle_cnt_r;
      if (watchdog_s && !drain_ok_s)
        err_timeout_r <= 1'b1;
      else
        err_timeout_r <= err_timeout_r;
    end else begin
      idle_cnt_r <= 32'd0;
    end
  end
`else
  assign watchdog_s      = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // Next-state logic of the job sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.job_valid) state_s = S_ISSUE;
        else               state_s = S_IDLE;
      end
      S_ISSUE: begin
        // Empty phases are skipped entirely so STREAM_* never waits on zero rows.
        if (!bus.ready)            state_s = S_ISSUE;
        else if (nw_r != CNT_ZERO)  state_s = S_STREAM_W;
        else if (nif_r != CNT_ZERO) state_s = S_STREAM_IF;
        else                       state_s = S_DRAIN;
      end
      S_STREAM_W: begin
        if (w_fire_s && w_last_s) state_s = (nif_r != CNT_ZERO) ? S_STREAM_IF : S_DRAIN;
        else                      state_s = S_STREAM_W;
      end
      S_STREAM_IF: begin
        if (if_fire_s && if_last_s) state_s = S_DRAIN;
        else                        state_s = S_STREAM_IF;
      end
      S_DRAIN: begin
        if (drain_ok_s)      state_s = S_DONE;
        else if (watchdog_s) state_s = S_DONE;
        else                 state_s = S_DRAIN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, descriptor, counters, registered row outputs and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      instr_r    <= {INSTR_SIZE{1'b0}};
      nw_r       <= CNT_ZERO;
      nif_r      <= CNT_ZERO;
      nout_r     <= CNT_ZERO;
      w_cnt_r    <= CNT_ZERO;
      if_cnt_r   <= CNT_ZERO;
      out_cnt_r  <= CNT_ZERO;
      w_valid_r  <= 1'b0;
      if_valid_r <= 1'b0;
      wdata_r    <= {RW{1'b0}};
      if_data_r  <= {RW{1'b0}};
      err_ovf_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      w_valid_r  <= w_fire_s;
      if_valid_r <= if_fire_s;
      if (w_fire_s)  wdata_r   <= bus.wrow_data;
      if (if_fire_s) if_data_r <= bus.ifrow_data;
      if (job_fire_s) begin
        instr_r   <= bus.job_instr;
        nw_r      <= bus.job_nw;
        nif_r     <= bus.job_nif;
        nout_r    <= bus.job_nout;
        w_cnt_r   <= CNT_ZERO;
        if_cnt_r  <= CNT_ZERO;
        out_cnt_r <= CNT_ZERO;
        err_ovf_r <= 1'b0;
      end else begin
        if (w_fire_s)  w_cnt_r  <= w_cnt_r  + CNT_W'(1'b1);
        if (if_fire_s) if_cnt_r <= if_cnt_r + CNT_W'(1'b1);
        // Dropped rows still count toward nout so DRAIN cannot stall on them.
        if (push_s && (out_cnt_r != {CNT_W{1'b1}})) out_cnt_r <= out_cnt_r + CNT_W'(1'b1);
        if (push_s && !wr_en_s) err_ovf_r <= 1'b1;
      end
    end
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      count_r <= count_r + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
    end
  end

  // Result FIFO storage; contents are only visible while res_valid is high.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= {bus.o_data, bus.read_out};
  end

  assign bus.job_ready   = state_r == S_IDLE;
  assign bus.busy        = state_r != S_IDLE;
  assign bus.done        = state_r == S_DONE;
  assign bus.start       = issue_fire_s;
  assign bus.instr_valid = issue_fire_s;
  assign bus.instr       = issue_fire_s ? instr_r : {INSTR_SIZE{1'b0}};
  assign bus.wrow_ready  = state_r == S_STREAM_W;
  assign bus.ifrow_ready = state_r == S_STREAM_IF;
  assign bus.w_valid     = {sys_cols{w_valid_r}};
  assign bus.if_valid    = {sys_cols{if_valid_r}};
  assign bus.wdata       = wdata_r;
  assign bus.if_data     = if_data_r;
  assign bus.res_valid   = res_valid_s;
  assign bus.res_data    = res_valid_s ? rd_entry_s[EW-1:sys_cols] : {PW{1'b0}};
  assign bus.res_mask    = res_valid_s ? rd_entry_s[sys_cols-1:0] : COL_ZERO;
  assign bus.err_ovf     = err_ovf_r;
endmodule

// File: tb/tb_acc_stream_master.sv
// ---------------------------------------------------------------------------
// tb_acc_stream_master
// Directed bench for acc_stream_master. A job-level reference model (phase,
// row counters, a result queue) predicts every output each cycle; directed
// scenarios add literal expectations on counts and data.
// ---------------------------------------------------------------------------
module tb_acc_stream_master;
  localparam int SC = 4, WB = 8, PB = 32, IS = 32, CW = 16, RD = 4, TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_stream_master_if #(.sys_cols(SC), .W_BITWIDTH(WB), .P_BITWIDTH(PB),
                         .INSTR_SIZE(IS), .CNT_W(CW)) bus ();

  acc_stream_master #(.sys_cols(SC), .W_BITWIDTH(WB), .P_BITWIDTH(PB),
                      .INSTR_SIZE(IS), .CNT_W(CW), .RES_DEPTH(RD),
                      .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0, bad = 0;
  bit en = 1'b0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phase 0..5 = idle..done) -------------
  int ph = 0, m_nw = 0, m_nif = 0, m_nout = 0, m_wc = 0, m_ic = 0, m_oc = 0, m_idle = 0;
  logic [31:0]  m_instr = 32'h0, m_wd = 32'h0, m_ifd = 32'h0;
  bit           m_wv = 1'b0, m_ifv = 1'b0, m_ovf = 1'b0, m_to = 1'b0;
  logic [131:0] m_q[$];
  bit           e_iss, m_full, m_pop, m_exit;
  logic [127:0] e_d;
  logic [3:0]   e_m;

  // monitors
  int n_wv = 0, n_ifv = 0, n_done = 0, n_iv = 0;
  logic [31:0]  w_seen[$];
  logic [31:0]  if_seen[$];
  logic [127:0] res_seen[$];

  always @(negedge clk) begin
    if (en) begin
      e_iss = (ph == 1) && (bus.ready == 1'b1);
      if (m_q.size() != 0) begin
        e_d = m_q[0][131:4];
        e_m = m_q[0][3:0];
      end else begin
        e_d = 128'h0;
        e_m = 4'h0;
      end
      chk("job_ready",   bus.job_ready,   ph == 0);
      chk("busy",        bus.busy,        ph != 0);
      chk("done",        bus.done,        ph == 5);
      chk("start",       bus.start,       e_iss);
      chk("instr_valid", bus.instr_valid, e_iss);
      chk("instr",       bus.instr,       e_iss ? m_instr : 32'h0);
      chk("wrow_ready",  bus.wrow_ready,  ph == 2);
      chk("ifrow_ready", bus.ifrow_ready, ph == 3);
      chk("w_valid",     bus.w_valid,     m_wv ? 4'hF : 4'h0);
      chk("wdata",       bus.wdata,       m_wd);
      chk("if_valid",    bus.if_valid,    m_ifv ? 4'hF : 4'h0);
      chk("if_data",     bus.if_data,     m_ifd);
      chk("res_valid",   bus.res_valid,   m_q.size() != 0);
      chk("res_data",    bus.res_data,    e_d);
      chk("res_mask",    bus.res_mask,    e_m);
      chk("err_ovf",     bus.err_ovf,     m_ovf);
      chk("err_timeout", bus.err_timeout, m_to);
      if (bus.w_valid != 4'h0)  begin n_wv++;  w_seen.push_back(bus.wdata);   end
      if (bus.if_valid != 4'h0) begin n_ifv++; if_seen.push_back(bus.if_data); end
      if (bus.done)        n_done++;
      if (bus.instr_valid) n_iv++;
      if (bus.res_valid && bus.res_ready) res_seen.push_back(bus.res_data);
    end
    // advance model to the state after the coming posedge
    if (rst) begin
      ph = 0; m_wc = 0; m_ic = 0; m_oc = 0; m_idle = 0;
      m_nw = 0; m_nif = 0; m_nout = 0; m_instr = 32'h0;
      m_wd = 32'h0; m_ifd = 32'h0; m_wv = 1'b0; m_ifv = 1'b0;
      m_ovf = 1'b0; m_to = 1'b0; m_q.delete();
    end else begin
      m_full = (m_q.size() == RD);
      m_pop  = (m_q.size() != 0) && bus.res_ready;
      m_exit = (m_oc >= m_nout);
      if (m_pop) void'(m_q.pop_front());
      if (ph != 0 && bus.read_out != 4'h0) begin
        if (!m_full || m_pop) m_q.push_back({bus.o_data, bus.read_out});
        else                  m_ovf = 1'b1;
        if (m_oc < 65535) m_oc++;
      end
      m_wv = 1'b0; m_ifv = 1'b0;
      case (ph)
        0: if (bus.job_valid) begin
             m_instr = bus.job_instr; m_nw = bus.job_nw; m_nif = bus.job_nif;
             m_nout = bus.job_nout; m_wc = 0; m_ic = 0; m_oc = 0;
             m_ovf = 1'b0; m_to = 1'b0; ph = 1;
           end
        1: if (bus.ready) ph = (m_nw != 0) ? 2 : ((m_nif != 0) ? 3 : 4);
        2: if (bus.wrow_valid) begin
             m_wv = 1'b1; m_wd = bus.wrow_data; m_wc++;
             if (m_wc >= m_nw) ph = (m_nif != 0) ? 3 : 4;
           end
        3: if (bus.ifrow_valid) begin
             m_ifv = 1'b1; m_ifd = bus.ifrow_data; m_ic++;
             if (m_ic >= m_nif) ph = 4;
           end
        4: begin
             if (m_exit) ph = 5;
`ifdef ACC_STREAM_TIMEOUT_EN
             else if (m_idle >= TO) begin ph = 5; m_to = 1'b1; end
             else if (bus.read_out != 4'h0) m_idle = 0;
             else m_idle++;
`endif
           end
        5: ph = 0;
        default: ph = 0;
      endcase
      if (ph != 4) m_idle = 0;
    end
  end

  // ---------------- stimulus ----------------------------------------------
  logic [31:0] stim [8];
  int b_wv, b_ifv, b_done, b_iv;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_job(input logic [31:0] ins, input int nw, input int nif, input int nout);
    bus.job_instr = ins;
    bus.job_nw    = 16'(nw);
    bus.job_nif   = 16'(nif);
    bus.job_nout  = 16'(nout);
    bus.job_valid = 1'b1;
    cyc(1);
    bus.job_valid = 1'b0;
  endtask

  task automatic send_rows(input bit is_if, input int n, input bit gaps);
    int k;
    for (int i = 0; i < n; i++) begin
      if (is_if) begin bus.ifrow_valid = 1'b1; bus.ifrow_data = stim[i]; end
      else       begin bus.wrow_valid  = 1'b1; bus.wrow_data  = stim[i]; end
      k = 0;
      @(negedge clk);
      while (!(is_if ? bus.ifrow_ready : bus.wrow_ready) && k < 50) begin k++; @(negedge clk); end
      chk("row_accept_wait", k < 50, 1'b1);
      @(posedge clk); #1;
      bus.wrow_valid = 1'b0; bus.ifrow_valid = 1'b0;
      if (gaps) cyc(1);
    end
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && k < budget) begin k++; @(negedge clk); end
    chk(nm, k < budget, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.job_valid = 1'b0; bus.job_instr = 32'h0; bus.job_nw = 16'h0;
    bus.job_nif = 16'h0; bus.job_nout = 16'h0;
    bus.wrow_valid = 1'b0; bus.wrow_data = 32'h0;
    bus.ifrow_valid = 1'b0; bus.ifrow_data = 32'h0;
    bus.res_ready = 1'b1; bus.ready = 1'b1;
    bus.read_out = 4'h0; bus.o_data = 128'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    en = 1'b1;
    cyc(2);
    chk("reset_job_ready", bus.job_ready, 1'b1);
    chk("reset_busy",      bus.busy,      1'b0);
    chk("reset_res_valid", bus.res_valid, 1'b0);
    rst = 1'b0;
    cyc(1);

    // basic job: 4 weight rows, 4 feature rows, 4 outputs
    b_wv = n_wv; b_ifv = n_ifv; b_done = n_done;
    w_seen.delete(); if_seen.delete(); res_seen.delete();
    send_job(32'hA5A5_0001, 4, 4, 4);
    stim[0] = 32'h0403_0201; stim[1] = 32'h1413_1211; stim[2] = 32'h2423_2221; stim[3] = 32'h3433_3231;
    send_rows(1'b0, 4, 1'b0);
    stim[0] = 32'hA0B0_C0D0; stim[1] = 32'hA1B1_C1D1; stim[2] = 32'hA2B2_C2D2; stim[3] = 32'hA3B3_C3D3;
    send_rows(1'b1, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.read_out = 4'hF;
      bus.o_data   = {4{32'h1000_0000 + 32'(i)}};
      cyc(1);
    end
    bus.read_out = 4'h0;
    wait_done(50, "basic_done_wait");
    cyc(1);
    chk("basic_w_count",  n_wv - b_wv,   4);
    chk("basic_if_count", n_ifv - b_ifv, 4);
    chk("basic_done_cnt", n_done - b_done, 1);
    chk("basic_w0",  w_seen[0],  32'h0403_0201);
    chk("basic_w3",  w_seen[3],  32'h3433_3231);
    chk("basic_if3", if_seen[3], 32'hA3B3_C3D3);
    chk("basic_res_cnt", res_seen.size(), 4);
    chk("basic_res0", res_seen[0], 128'h10000000_10000000_10000000_10000000);
    chk("basic_res3", res_seen[3], 128'h10000003_10000003_10000003_10000003);

    // issue stalls on ready, and all-zero counts
    b_iv = n_iv; b_wv = n_wv; b_done = n_done;
    bus.ready = 1'b0;
    send_job(32'h0000_BEEF, 0, 0, 0);
    cyc(10);
    chk("stall_no_issue", n_iv - b_iv, 0);
    chk("stall_busy", bus.busy, 1'b1);
    bus.ready = 1'b1;
    wait_done(10, "zero_done_wait");
    chk("stall_issue_once", n_iv - b_iv, 1);
    chk("zero_no_w", n_wv - b_wv, 0);
    chk("zero_done_cnt", n_done - b_done, 1);

    // overflow: 5 rows into a 4-deep FIFO, then full push with simultaneous pop
    res_seen.delete();
    bus.res_ready = 1'b0;
    send_job(32'h0000_0002, 0, 0, 6);
    for (int i = 0; i < 5; i++) begin
      bus.read_out = 4'hF;
      bus.o_data   = {4{32'h2000_0000 + 32'(i)}};
      cyc(1);
    end
    bus.read_out = 4'h0;
    cyc(1);
    chk("ovf_flag", bus.err_ovf, 1'b1);
    chk("ovf_res_valid", bus.res_valid, 1'b1);
    bus.read_out = 4'h5;
    bus.o_data = {4{32'h2000_0005}};
    bus.res_ready = 1'b1;
    cyc(1);
    bus.read_out = 4'h0;
    wait_done(20, "ovf_done_wait");
    cyc(4);
    chk("ovf_res_cnt", res_seen.size(), 5);
    chk("ovf_res0", res_seen[0], 128'h20000000_20000000_20000000_20000000);
    chk("ovf_res3", res_seen[3], 128'h20000003_20000003_20000003_20000003);
    chk("ovf_res4", res_seen[4], 128'h20000005_20000005_20000005_20000005);
    chk("ovf_sticky", bus.err_ovf, 1'b1);

    // upstream gaps on the weight stream
    w_seen.delete();
    b_wv = n_wv;
    send_job(32'h0000_0003, 3, 1, 0);
    chk("gap_ovf_cleared", bus.err_ovf, 1'b0);
    stim[0] = 32'hC0FF_EE01; stim[1] = 32'hC0FF_EE02; stim[2] = 32'hC0FF_EE03;
    send_rows(1'b0, 3, 1'b1);
    stim[0] = 32'hDEAD_0001;
    send_rows(1'b1, 1, 1'b0);
    wait_done(20, "gap_done_wait");
    chk("gap_w_count", n_wv - b_wv, 3);
    chk("gap_w1", w_seen[1], 32'hC0FF_EE02);
    chk("gap_w2", w_seen[2], 32'hC0FF_EE03);

    // reset in the middle of STREAM_W
    b_done = n_done;
    send_job(32'h0000_0004, 4, 0, 0);
    stim[0] = 32'h5555_0001; stim[1] = 32'h5555_0002;
    send_rows(1'b0, 2, 1'b0);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_busy",      bus.busy,      1'b0);
    chk("rst_mid_w_valid",   bus.w_valid,   4'h0);
    chk("rst_mid_wdata",     bus.wdata,     32'h0);
    chk("rst_mid_job_ready", bus.job_ready, 1'b1);
    rst = 1'b0;
    cyc(2);
    chk("rst_mid_no_done", n_done - b_done, 0);

`ifdef ACC_STREAM_TIMEOUT_EN
    // drain watchdog with no read_out
    send_job(32'h0000_0005, 0, 0, 1);
    wait_done(40, "timeout_done_wait");
    chk("timeout_flag", bus.err_timeout, 1'b1);
`endif

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
